j_acc_collector_mx_cell: RTL and testbench

J_ACC_COLLECTOR_MX_CELL -- requirements
Module: j_acc_collector_MX_cell

---
 rtl/j_acc_collector_mx_cell.sv | 222 ++++++++++++++++++++++
 tb/tb_j_acc_collector_mx_cell.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/j_acc_collector_mx_cell.sv
// 32-channel serial-to-word collector: assembles LSB-first words per channel and
// drains them round-robin into a single-port SRAM write stream.
module j_acc_collector_mx_cell #(
  parameter int SRAM_DEPTH  = 1024,
  parameter int SRAM_ADDR_W = $clog2(SRAM_DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      collect_start,
  output logic                      collect_idle,
  input  logic [SRAM_ADDR_W*32-1:0] base_addr,
  input  logic [SRAM_ADDR_W-1:0]    img_size,
  input  logic [31:0]               serial_input,
  input  logic [31:0]               serial_en,
  input  logic [31:0]               serial_start,
  output logic                      sram_en,
  output logic                      sram_we,
  output logic [SRAM_ADDR_W-1:0]    sram_addr,
  output logic [31:0]               sram_wdata,
  output logic [31:0]               err_overflow,
  output logic [31:0]               err_frame
);

  localparam int NCH   = 32;
  localparam int CNT_W = SRAM_ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic [SRAM_ADDR_W-1:0] base_q    [NCH];
  logic [SRAM_ADDR_W-1:0] base_d    [NCH];
  logic [4:0]             bit_cnt_q [NCH];
  logic [4:0]             bit_cnt_d [NCH];
  logic [31:0]            shift_q   [NCH];
  logic [31:0]            shift_d   [NCH];
  logic [31:0]            hold_q    [NCH];
  logic [31:0]            hold_d    [NCH];
  logic [CNT_W-1:0]       wr_cnt_q  [NCH];
  logic [CNT_W-1:0]       wr_cnt_d  [NCH];
  logic [SRAM_ADDR_W-1:0] img_q, img_d;
  logic [NCH-1:0]         pending_q, pending_d;
  logic [NCH-1:0]         err_ovf_q, err_ovf_d;
  logic [NCH-1:0]         err_frm_q, err_frm_d;
  logic [4:0]             ptr_q, ptr_d;
  logic                   gnt_vld_q, gnt_vld_d;
  logic [SRAM_ADDR_W-1:0] gnt_addr_q, gnt_addr_d;
  logic [31:0]            gnt_data_q, gnt_data_d;
  logic                   sram_we_q, sram_we_d;
  logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]            sram_wdata_q, sram_wdata_d;

  // Arbiter and quota bookkeeping.
  logic             gnt_any;
  logic [4:0]       gnt_idx;
  logic [4:0]       cand;
  logic [NCH-1:0]   quota_full;
  logic             all_full;
  logic [CNT_W-1:0] img_plus1;
  logic [CNT_W-1:0] accepted;
  logic [CNT_W-1:0] addr_sum;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    gnt_any    = 1'b0;
    gnt_idx    = '0;
    cand       = '0;
    quota_full = '0;
    all_full   = 1'b1;
    accepted   = '0;
    img_plus1  = {1'b0, img_q} + CNT_W'(1);
    // Scan downward from the farthest offset so the nearest pending channel wins.
    for (int k = NCH - 1; k >= 0; k--) begin
      cand = ptr_q + 5'(k);
      if (pending_q[cand] && state_q == S_RUN) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    // A channel's quota counts words already written plus the one waiting in hold.
    for (int c = 0; c < NCH; c++) begin
      accepted      = wr_cnt_q[c] + CNT_W'(pending_q[c]);
      quota_full[c] = (accepted >= img_plus1);
      all_full      = all_full && (wr_cnt_q[c] == img_plus1);
    end
    addr_sum = {1'b0, base_q[gnt_idx]} + {1'b0, wr_cnt_q[gnt_idx][SRAM_ADDR_W-1:0]};
    if (addr_sum >= CNT_W'(SRAM_DEPTH)) addr_sum = addr_sum - CNT_W'(SRAM_DEPTH);
  end

  logic [4:0]  pos;
  logic [31:0] word;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    wr_cnt_d     = wr_cnt_q;
    img_d        = img_q;
    pending_d    = pending_q;
    err_ovf_d    = err_ovf_q;
    err_frm_d    = err_frm_q;
    ptr_d        = ptr_q;
    gnt_vld_d    = 1'b0;
    gnt_addr_d   = gnt_addr_q;
    gnt_data_d   = gnt_data_q;
    pos          = '0;
    word         = '0;
    // Output stage drains the grant stage regardless of FSM state.
    sram_we_d    = gnt_vld_q;
    sram_addr_d  = gnt_vld_q ? gnt_addr_q : sram_addr_q;
    sram_wdata_d = gnt_vld_q ? gnt_data_q : sram_wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (collect_start) begin
          for (int c = 0; c < NCH; c++) begin
            base_d[c]    = base_addr[c*SRAM_ADDR_W +: SRAM_ADDR_W];
            bit_cnt_d[c] = '0;
            wr_cnt_d[c]  = '0;
          end
          img_d     = img_size;
          pending_d = '0;
          err_ovf_d = '0;
          err_frm_d = '0;
          ptr_d     = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        if (gnt_any) begin
          pending_d[gnt_idx] = 1'b0;
          wr_cnt_d[gnt_idx]  = wr_cnt_q[gnt_idx] + CNT_W'(1);
          ptr_d              = gnt_idx + 5'd1;
          gnt_vld_d          = 1'b1;
          gnt_addr_d         = addr_sum[SRAM_ADDR_W-1:0];
          gnt_data_d         = hold_q[gnt_idx];
        end
        for (int c = 0; c < NCH; c++) begin
          if (serial_en[c]) begin
            pos = serial_start[c] ? 5'd0 : bit_cnt_q[c];
            if (serial_start[c] && bit_cnt_q[c] != 5'd0) err_frm_d[c] = 1'b1;
            word      = (pos == 5'd0) ? 32'h0 : shift_q[c];
            word[pos] = serial_input[c];
            if (pos == 5'd31) begin
              bit_cnt_d[c] = '0;
              if (quota_full[c]) begin
                // Channel already has its full image; extra words vanish silently.
              end else if (pending_q[c] && !(gnt_any && gnt_idx == 5'(c))) begin
                err_ovf_d[c] = 1'b1;
              end else begin
                hold_d[c]    = word;
                pending_d[c] = 1'b1;
              end
            end else begin
              bit_cnt_d[c] = pos + 5'd1;
              shift_d[c]   = word;
            end
          end
        end
        if (all_full && !gnt_vld_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      img_q        <= '0;
      pending_q    <= '0;
      err_ovf_q    <= '0;
      err_frm_q    <= '0;
      ptr_q        <= '0;
      gnt_vld_q    <= 1'b0;
      gnt_addr_q   <= '0;
      gnt_data_q   <= '0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      // NOTE: the per-channel arrays are plain flops, not RAM, so they can and must be reset.
      for (int c = 0; c < NCH; c++) begin
        base_q[c]    <= '0;
        bit_cnt_q[c] <= '0;
        shift_q[c]   <= '0;
        hold_q[c]    <= '0;
        wr_cnt_q[c]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      img_q        <= img_d;
      pending_q    <= pending_d;
      err_ovf_q    <= err_ovf_d;
      err_frm_q    <= err_frm_d;
      ptr_q        <= ptr_d;
      gnt_vld_q    <= gnt_vld_d;
      gnt_addr_q   <= gnt_addr_d;
      gnt_data_q   <= gnt_data_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      for (int c = 0; c < NCH; c++) begin
        base_q[c]    <= base_d[c];
        bit_cnt_q[c] <= bit_cnt_d[c];
        shift_q[c]   <= shift_d[c];
        hold_q[c]    <= hold_d[c];
        wr_cnt_q[c]  <= wr_cnt_d[c];
      end
    end
  end

  assign collect_idle = (state_q == S_IDLE);
  assign sram_en      = sram_we_q;
  assign sram_we      = sram_we_q;
  assign sram_addr    = sram_addr_q;
  assign sram_wdata   = sram_wdata_q;
  assign err_overflow = err_ovf_q;
  assign err_frame    = err_frm_q;

endmodule

// File: tb/tb_j_acc_collector_mx_cell.sv
// Self-checking bench for j_acc_collector_mx_cell: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a word-level reference model.
module tb_j_acc_collector_mx_cell;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           collect_start;
  logic           collect_idle;
  logic [AW*32-1:0] base_addr;
  logic [AW-1:0]  img_size;
  logic [31:0]    serial_input, serial_en, serial_start;
  logic           sram_en, sram_we;
  logic [AW-1:0]  sram_addr;
  logic [31:0]    sram_wdata, err_overflow, err_frame;

  j_acc_collector_mx_cell #(.SRAM_DEPTH(DEPTH), .SRAM_ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .collect_start(collect_start), .collect_idle(collect_idle),
    .base_addr(base_addr), .img_size(img_size), .serial_input(serial_input),
    .serial_en(serial_en), .serial_start(serial_start), .sram_en(sram_en), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .err_overflow(err_overflow),
    .err_frame(err_frame)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int last_bit_cyc = 0;
  int idle_cyc = 0;
  int en_mismatch = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } wr_t;
  wr_t         wq[$];
  logic [31:0] tb_mem [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sram_en !== sram_we) en_mismatch++;
    if (sram_we === 1'b1) begin
      wq.push_back('{sram_addr, sram_wdata, cyc});
      tb_mem[sram_addr] = sram_wdata;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bases(input int stride);
    for (int c = 0; c < 32; c++) base_addr[c*AW +: AW] = AW'(c * stride);
  endtask

  task automatic start_run(input logic [AW-1:0] img);
    img_size      = img;
    collect_start = 1'b1;
    tick();
    collect_start = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] mask, input logic [31:0] data,
                           input int nbits, input int gap);
    for (int b = 0; b < nbits; b++) begin
      serial_en    = mask;
      serial_start = (b == 0) ? mask : 32'h0;
      serial_input = data[b] ? mask : 32'h0;
      tick();
      last_bit_cyc = cyc;
      serial_en    = '0;
      serial_start = '0;
      serial_input = '0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k = 0;
    while (wq.size() < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (collect_idle !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check(name, collect_idle, 1);
    idle_cyc = cyc;
  endtask

  typedef struct {
    int            ch;
    logic [AW-1:0] base;
    logic [31:0]   data;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_data;
    int            exp_lat;
  } vec_t;

  // Reference model state for the randomized runs.
  logic [31:0] m_cur  [32];
  int          m_len  [32];
  logic [31:0] m_word [32][8];
  int          m_cnt  [32];
  logic [31:0] m_frm;
  logic [AW-1:0] m_base [32];

  initial begin
    vec_t vec [5];
    vec[0] = '{5,  10'h010, 32'hA5A5_0001, 10'h010, 32'hA5A5_0001, 2};
    vec[1] = '{0,  10'h000, 32'hFFFF_FFFF, 10'h000, 32'hFFFF_FFFF, 2};
    vec[2] = '{31, 10'h3FF, 32'h8000_0000, 10'h3FF, 32'h8000_0000, 2};
    vec[3] = '{17, 10'h155, 32'h0000_0000, 10'h155, 32'h0000_0000, 2};
    vec[4] = '{12, 10'h2AA, 32'hDEAD_BEEF, 10'h2AA, 32'hDEAD_BEEF, 2};

    collect_start = 1'b0;
    base_addr     = '0;
    img_size      = '0;
    serial_input  = '0;
    serial_en     = '0;
    serial_start  = '0;
    reset_n       = 1'b1;
    #1 reset_n    = 1'b0;
    #2;
    check("rst_idle", collect_idle, 1);
    check("rst_en_we", {sram_en, sram_we}, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_wdata", sram_wdata, 0);
    check("rst_errs", {err_overflow, err_frame}, 0);
    tick();
    tick();
    reset_n = 1'b1;
    // serial_en in IDLE must be ignored.
    send_bits('1, 32'h1234_5678, 32, 0);
    tick();
    check("idle_ignores_serial", wq.size(), 0);

    // Single-word vectors; the other 31 channels then finish so the run completes.
    for (int i = 0; i < 5; i++) begin
      logic [31:0] mask;
      mask = 32'h1 << vec[i].ch;
      set_bases(32);
      base_addr[vec[i].ch*AW +: AW] = vec[i].base;
      start_run('0);
      check($sformatf("vec%0d_busy", i), collect_idle, 0);
      wq.delete();
      send_bits(mask, vec[i].data, 32, 0);
      wait_writes(1, 10);
      tick(); tick(); tick();
      check($sformatf("vec%0d_count", i), wq.size(), 1);
      if (wq.size() >= 1) begin
        check($sformatf("vec%0d_addr", i), wq[0].addr, vec[i].exp_addr);
        check($sformatf("vec%0d_data", i), wq[0].data, vec[i].exp_data);
        check($sformatf("vec%0d_lat", i), wq[0].cyc - last_bit_cyc, vec[i].exp_lat);
      end
      check($sformatf("vec%0d_still_run", i), collect_idle, 0);
      send_bits(~mask, 32'h0, 32, 0);
      wait_idle(100, $sformatf("vec%0d_done", i));
      check($sformatf("vec%0d_total", i), wq.size(), 32);
    end

    // Contention: all channels complete on the same edge.
    set_bases(32);
    start_run('0);
    wq.delete();
    send_bits('1, 32'hC0FF_EE00, 32, 0);
    wait_idle(100, "cont_done");
    check("cont_count", wq.size(), 32);
    for (int i = 0; i < 32 && i < wq.size(); i++)
      check($sformatf("cont_order%0d", i), {wq[i].addr, 32'(wq[i].cyc - last_bit_cyc)},
            {AW'(i * 32), 32'(2 + i)});
    if (wq.size() == 32) check("cont_done_timing", idle_cyc - wq[31].cyc, 2);
    check("cont_no_ovf", err_overflow, 0);

    // Bulk: 32 channels x 32 words in lockstep.
    for (int a = 0; a < DEPTH; a++) tb_mem[a] = 32'hFFFF_FFFF;
    set_bases(32);
    start_run(10'd31);
    wq.delete();
    for (int k = 0; k < 32; k++) send_bits('1, 32'(k), 32, 0);
    wait_idle(200, "bulk_done");
    check("bulk_count", wq.size(), 1024);
    begin
      int bad = 0;
      for (int c = 0; c < 32; c++)
        for (int k = 0; k < 32; k++)
          if (tb_mem[c*32 + k] !== 32'(k)) bad++;
      check("bulk_mem_bad_words", bad, 0);
    end
    check("bulk_errs", {err_overflow, err_frame}, 0);

    // Framing error on channel 3: restart after 10 bits.
    set_bases(32);
    start_run('0);
    wq.delete();
    send_bits(32'h8, 32'h0000_03FF, 10, 0);
    send_bits(32'h8, 32'h1234_5678, 32, 0);
    wait_writes(1, 10);
    tick(); tick();
    check("frm_count", wq.size(), 1);
    if (wq.size() >= 1) check("frm_data", {wq[0].addr, wq[0].data}, {10'd96, 32'h1234_5678});
    check("frm_flag", err_frame, 32'h8);
    send_bits(~32'h8, 32'h0, 32, 0);
    wait_idle(100, "frm_done");
    check("frm_sticky", err_frame, 32'h8);
    check("frm_total", wq.size(), 32);

    // Gapped input and address wrap on channel 7.
    set_bases(32);
    base_addr[7*AW +: AW] = AW'(DEPTH - 1);
    start_run(10'd1);
    wq.delete();
    send_bits(32'h80, 32'h7777_AAAA, 32, 2);
    send_bits(32'h80, 32'h0F0F_1234, 32, 2);
    wait_writes(2, 10);
    check("wrap_count", wq.size(), 2);
    if (wq.size() >= 2) begin
      check("wrap_w0", {wq[0].addr, wq[0].data}, {10'h3FF, 32'h7777_AAAA});
      check("wrap_w1", {wq[1].addr, wq[1].data}, {10'h000, 32'h0F0F_1234});
    end
    send_bits(~32'h80, 32'h5, 32, 0);
    send_bits(~32'h80, 32'h6, 32, 0);
    wait_idle(100, "wrap_done");
    check("wrap_total", wq.size(), 64);

    // Reset mid-run with writes outstanding.
    set_bases(32);
    start_run(10'd3);
    send_bits('1, 32'hFACE_0000, 32, 0);
    tick(); tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    check("mrst_idle", collect_idle, 1);
    check("mrst_outputs", {sram_en, sram_we, sram_addr, sram_wdata}, 0);
    tick();
    reset_n = 1'b1;
    wq.delete();
    send_bits('1, 32'hFFFF_0000, 32, 0);
    repeat (40) tick();
    check("mrst_no_writes", wq.size(), 0);
    start_run('0);
    send_bits('1, 32'h0BAD_F00D, 32, 0);
    wait_idle(100, "mrst_clean_done");
    check("mrst_clean_count", wq.size(), 32);
    begin
      int bad = 0;
      foreach (wq[i]) if (wq[i].data !== 32'h0BAD_F00D || wq[i].addr !== AW'(i * 32)) bad++;
      check("mrst_clean_bad", bad, 0);
    end

    // Randomized traffic against the word-level model.
    for (int it = 0; it < 3; it++) begin
      logic [AW-1:0] img;
      int guard;
      int done_ch;
      img = AW'($urandom_range(0, 3));
      for (int c = 0; c < 32; c++) begin
        m_base[c] = AW'(c * 8 + $urandom_range(0, 4));
        base_addr[c*AW +: AW] = m_base[c];
        m_cur[c] = '0;
        m_len[c] = 0;
        m_cnt[c] = 0;
      end
      m_frm = '0;
      start_run(img);
      wq.delete();
      guard   = 0;
      done_ch = 0;
      while (done_ch < 32 && guard < 4000) begin
        for (int c = 0; c < 32; c++) begin
          serial_en[c] = 1'b0; serial_start[c] = 1'b0; serial_input[c] = 1'b0;
          if (m_cnt[c] < int'(img) + 1) begin
            serial_en[c]    = 1'($urandom_range(0, 1));
            serial_input[c] = 1'($urandom_range(0, 1));
            if (m_len[c] == 0) serial_start[c] = 1'($urandom_range(0, 1));
            else serial_start[c] = ($urandom_range(0, 63) == 0);
          end
        end
        tick();
        done_ch = 0;
        for (int c = 0; c < 32; c++) begin
          if (serial_en[c]) begin
            if (serial_start[c]) begin
              if (m_len[c] != 0) m_frm[c] = 1'b1;
              m_len[c] = 0;
            end
            m_cur[c] = {serial_input[c], m_cur[c][31:1]};
            m_len[c]++;
            if (m_len[c] == 32) begin
              m_word[c][m_cnt[c]] = m_cur[c];
              m_cnt[c]++;
              m_len[c] = 0;
            end
          end
          if (m_cnt[c] >= int'(img) + 1) done_ch++;
        end
        guard++;
      end
      serial_en = '0; serial_start = '0; serial_input = '0;
      wait_idle(200, $sformatf("rnd%0d_done", it));
      check($sformatf("rnd%0d_count", it), wq.size(), 32 * (int'(img) + 1));
      begin
        int idx [32];
        int bad = 0;
        for (int c = 0; c < 32; c++) idx[c] = 0;
        foreach (wq[i]) begin
          int c;
          c = int'(wq[i].addr) / 8;
          if (idx[c] >= m_cnt[c] || wq[i].data !== m_word[c][idx[c]] ||
              wq[i].addr !== m_base[c] + AW'(idx[c])) bad++;
          idx[c]++;
        end
        check($sformatf("rnd%0d_bad_writes", it), bad, 0);
      end
      check($sformatf("rnd%0d_frame", it), err_frame, m_frm);
      check($sformatf("rnd%0d_ovf", it), err_overflow, 0);
    end

    check("en_equals_we", en_mismatch, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
